// File: rtl/hamming_encode_arbiter.sv
// Round-robin arbiter sharing one external Hamming encoder, with a credit-checked output FIFO and drain/flush FSM.
// Optional statistics counters are enabled by defining HAMMING_ARB_STATS_EN.
package hamming_encode_arbiter_pkg;
  function automatic int coded_width(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return dw + p + 1;
  endfunction
endpackage

module hamming_encode_arbiter
  import hamming_encode_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int ENC_LATENCY = 1,
  parameter int OUT_DEPTH   = 4,
  localparam int CODED_WIDTH = coded_width(DATA_WIDTH),
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
)(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          enc_valid_o,
  output logic [DATA_WIDTH-1:0]         enc_data_o,
  input  logic [CODED_WIDTH-1:0]        enc_coded_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CODED_WIDTH-1:0]        out_data_o,
  output logic [ID_WIDTH-1:0]           out_id_o,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic                          busy_o
`ifdef HAMMING_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt_o,
  output logic [15:0]                   stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CNT_W:0]    DEPTH_SUM = (CNT_W + 1)'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(OUT_DEPTH - 1);
  localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   w_flush_done;
  logic [ID_WIDTH-1:0]    r_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_inflight;
  logic                   w_credit_ok;
  logic                   w_grant;
  logic [ID_WIDTH-1:0]    w_grant_id;
  logic [NUM_REQ-1:0]     w_grant_vec;
  logic                   r_enc_valid;
  logic [DATA_WIDTH-1:0]  r_enc_data;
  logic [ID_WIDTH-1:0]    r_enc_id;
  logic                   w_push;
  logic [ID_WIDTH-1:0]    w_push_id;
  logic                   w_pop;
  logic [CODED_WIDTH-1:0] r_mem_data [OUT_DEPTH];
  logic [ID_WIDTH-1:0]    r_mem_id   [OUT_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;

  // Credit counts buffered plus in-flight words, so a pop frees a slot only from the next cycle.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_SUM;

  always_comb begin : p_arb
    int unsigned   idx;
    logic [ID_WIDTH-1:0] w_idx;
    idx         = 0;
    w_idx       = '0;
    w_grant     = 1'b0;
    w_grant_id  = '0;
    w_grant_vec = '0;
    if (!rst_i && (r_state == ST_RUN) && w_credit_ok) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx   = (32'(r_ptr) + i) % NUM_REQ;
        w_idx = ID_WIDTH'(idx);
        if (!w_grant && req_valid_i[w_idx]) begin
          w_grant    = 1'b1;
          w_grant_id = w_idx;
        end
      end
    end
    w_grant_vec[w_grant_id] = w_grant;
  end

  assign req_ready_o = w_grant_vec;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_grant_id == ID_LAST) ? '0 : w_grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_enc_valid <= 1'b0;
      r_enc_data  <= '0;
      r_enc_id    <= '0;
    end else begin
      r_enc_valid <= w_grant;
      if (w_grant) begin
        r_enc_data <= req_data_i[w_grant_id*DATA_WIDTH +: DATA_WIDTH];
        r_enc_id   <= w_grant_id;
      end
    end
  end

  assign enc_valid_o = r_enc_valid;
  assign enc_data_o  = r_enc_data;

  generate
    if (ENC_LATENCY == 0) begin : g_comb_enc
      assign w_push    = r_enc_valid;
      assign w_push_id = r_enc_id;
    end else begin : g_pipe_enc
      logic [ENC_LATENCY-1:0] r_sh_valid;
      logic [ID_WIDTH-1:0]    r_sh_id [ENC_LATENCY];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_sh_valid <= '0;
          for (int unsigned i = 0; i < ENC_LATENCY; i++) r_sh_id[i] <= '0;
        end else begin
          r_sh_valid[0] <= r_enc_valid;
          r_sh_id[0]    <= r_enc_id;
          for (int unsigned i = 1; i < ENC_LATENCY; i++) begin
            r_sh_valid[i] <= r_sh_valid[i-1];
            r_sh_id[i]    <= r_sh_id[i-1];
          end
        end
      end
      assign w_push    = r_sh_valid[ENC_LATENCY-1];
      assign w_push_id = r_sh_id[ENC_LATENCY-1];
    end
  endgenerate

  assign w_pop = (r_count != '0) && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= enc_coded_i;
      r_mem_id[r_wr_ptr]   <= w_push_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_grant, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign out_valid_o = (r_count != '0);
  assign out_data_o  = out_valid_o ? r_mem_data[r_rd_ptr] : '0;
  assign out_id_o    = out_valid_o ? r_mem_id[r_rd_ptr]   : '0;
  assign busy_o      = (r_count != '0) || (r_inflight != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_done = 1'b0;
    unique case (r_state)
      ST_RUN:   if (flush_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((r_inflight == '0) && (r_count == '0)) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_flush_done = 1'b1;
        w_state_nxt  = ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  assign flush_done_o = w_flush_done;

`ifdef HAMMING_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant && (r_grant_cnt[w_grant_id] != '1))
        r_grant_cnt[w_grant_id] <= r_grant_cnt[w_grant_id] + 1'b1;
      if ((|req_valid_i) && !w_grant && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_o[i*16 +: 16] = r_grant_cnt[i];
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Scoreboard bench for hamming_encode_arbiter: round-robin/credit/flush reference model plus an encoder model.
`timescale 1ns/1ps
module tb_hamming_encode_arbiter;
  localparam int DW = 32, NR = 4, OD = 4, CW = 39, IW = 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            enc_valid_o;
  logic [DW-1:0]   enc_data_o;
  logic [CW-1:0]   enc_coded_i = '0;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [CW-1:0]   out_data_o;
  logic [IW-1:0]   out_id_o;
  logic            flush_i;
  logic            flush_done_o;
  logic            busy_o;
`ifdef HAMMING_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  hamming_encode_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ENC_LATENCY(1), .OUT_DEPTH(OD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .enc_valid_o(enc_valid_o), .enc_data_o(enc_data_o),
    .enc_coded_i(enc_coded_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_id_o(out_id_o), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .busy_o(busy_o)
`ifdef HAMMING_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Hamming code: parity bits at power-of-two positions, data elsewhere, overall parity at bit 0.
  function automatic logic [CW-1:0] ham(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    for (int p = 0; (1 << p) < CW; p++)
      for (int pos = 1; pos < CW; pos++)
        if (((pos & (pos - 1)) != 0) && (((pos >> p) & 1) == 1))
          c[1 << p] = c[1 << p] ^ c[pos];
    c[0] = ^c;
    return c;
  endfunction

  // External encoder with one cycle of latency.
  always @(posedge clk) enc_coded_i <= ham(enc_data_o);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [CW-1:0] code;
  } exp_t;
  exp_t sb[$];

  bit armed = 1'b0;
  int m_occ = 0, m_ptr = 0, m_mode = M_RUN;
  int dut_acc = 0;

  // Reference model: grants, credit and drain sequencing, evaluated mid-cycle.
  always @(negedge clk) begin : model
    logic [NR-1:0] exp_rdy;
    int g;
    exp_rdy = '0;
    g = -1;
    if (armed) begin
      if (!rst_i && m_mode == M_RUN && m_occ < OD)
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid_i[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready_o, exp_rdy);
      check("busy", busy_o, m_occ != 0);
      check("flush_done", flush_done_o, m_mode == M_DONE);
      check("fifo_bound", dut.r_count <= OD, 1'b1);
      dut_acc += $countones(req_ready_o & req_valid_i);
      if (rst_i) begin
        m_occ = 0; m_ptr = 0; m_mode = M_RUN;
        sb.delete();
      end else begin
        case (m_mode)
          M_RUN:   if (flush_i) m_mode = M_DRAIN;
          M_DRAIN: if (m_occ == 0) m_mode = M_DONE;
          default: m_mode = M_RUN;
        endcase
        if (g >= 0) begin
          sb.push_back({g[IW-1:0], ham(req_data_i[g*DW +: DW])});
          m_occ++;
          m_ptr = (g + 1) % NR;
        end
        if (out_valid_o && out_ready_i) m_occ--;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed && !rst_i && out_valid_o && out_ready_i) begin
      check("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_id", out_id_o, e.id);
        check("out_data", out_data_o, e.code);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) req_data_i[i*DW +: DW] = $urandom;
  endtask

  initial begin
    int a0;
    bit seen;
    rst_i = 1'b1; req_valid_i = '0; out_ready_i = 1'b1; flush_i = 1'b0;
    rand_data();
    step();
    armed = 1'b1;
    step(); step();
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_enc_valid", enc_valid_o, 1'b0);
    check("rst_enc_data", enc_data_o, '0);
    check("rst_out_data", out_data_o, '0);
    check("rst_out_id", out_id_o, '0);
    check("rst_flush_done", flush_done_o, 1'b0);
    rst_i = 1'b0;
    step();

    // Single word through requester 2: enc at T+1, out at T+3.
    req_data_i[2*DW +: DW] = 32'hDEADBEEF;
    req_valid_i = 4'b0100;
    @(negedge clk);
    check("lat_grant", req_ready_o, 4'b0100);
    step();
    req_valid_i = '0;
    check("lat_enc_valid", enc_valid_o, 1'b1);
    check("lat_enc_data", enc_data_o, 32'hDEADBEEF);
    step();
    check("lat_out_early", out_valid_o, 1'b0);
    step();
    check("lat_out_valid", out_valid_o, 1'b1);
    check("lat_out_id", out_id_o, 2);
    check("lat_out_data", out_data_o, ham(32'hDEADBEEF));
    step();

    // All requesters streaming.
    req_valid_i = '1;
    repeat (16) begin rand_data(); step(); end

    // Consumer stalled: credit caps accepts at OUT_DEPTH.
    req_valid_i = '0;
    repeat (6) step();
    out_ready_i = 1'b0;
    req_valid_i = '1;
    a0 = dut_acc;
    repeat (10) begin rand_data(); step(); end
    check("full_accepts", dut_acc - a0, OD);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("no_grant_on_pop_cycle", req_ready_o, '0);
    step();
    @(negedge clk);
    check("grant_after_pop", |req_ready_o, 1'b1);
    step();

    // Flush with FIFO loaded.
    out_ready_i = 1'b0;
    repeat (6) begin rand_data(); step(); end
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    a0 = dut_acc;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (flush_done_o) seen = 1'b1;
      else step();
    end
    check("flush_done_seen", seen, 1'b1);
    check("flush_done_busy", busy_o, 1'b0);
    check("drain_grants", dut_acc - a0, 0);
    step();
    @(negedge clk);
    check("grant_after_done", |req_ready_o, 1'b1);
    step();

    // Reset with words in flight and buffered.
    out_ready_i = 1'b0;
    repeat (4) begin rand_data(); step(); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_valid_i = '0;
    check("midrst_out_valid", out_valid_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    out_ready_i = 1'b1;
    repeat (4) begin
      step();
      check("midrst_no_late_push", out_valid_o, 1'b0);
    end
    req_valid_i = '1;
    @(negedge clk);
    check("midrst_ptr0", req_ready_o, 4'b0001);
    step();

    // Randomized traffic.
    repeat (400) begin
      rand_data();
      req_valid_i = NR'($urandom);
      out_ready_i = ($urandom % 4) != 0;
      flush_i = ($urandom % 50) == 0;
      step();
    end

    req_valid_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) step();
    repeat (3) step();
    check("final_drain", sb.size(), 0);
    check("final_busy", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_encode_arbiter.md
Name: hamming_encode_arbiter

Overview:
- Shares one Hamming encoder between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Drives the encoder through a fixed-latency issue interface and tags every issued word with its requester ID.
- Buffers coded words in an output FIFO, with credit-based issue so no result is ever dropped.
- Sits between the producer ports and the encoder in the ECC write path; supports a drain/flush sequence.

Parameters:
- DATA_WIDTH, 32, payload width per requester.
- NUM_REQ, 4, number of requesters (>=2).
- ENC_LATENCY, 1, encoder cycles from enc_valid_o to enc_coded_i valid (0 = combinational encoder).
- OUT_DEPTH, 4, output FIFO entries (>=2).
- CODED_WIDTH, derived localparam: DATA_WIDTH + p + 1, where p is the smallest value with 2^p >= DATA_WIDTH+p+1. Default gives 39.
- ID_WIDTH, derived localparam: $clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester valid
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester payload, requester i in slice i
- req_ready_o  out  NUM_REQ  one-hot grant/accept
- enc_valid_o  out  1  word presented to encoder
- enc_data_o  out  DATA_WIDTH  encoder input
- enc_coded_i  in  CODED_WIDTH  encoder output, valid ENC_LATENCY cycles after enc_valid_o
- out_valid_o  out  1  coded word available
- out_ready_i  in  1  consumer accept
- out_data_o  out  CODED_WIDTH  coded word
- out_id_o  out  ID_WIDTH  originating requester
- flush_i  in  1  drain request (single-cycle pulse)
- flush_done_o  out  1  one-cycle pulse when drain completes
- busy_o  out  1  high when any word is in flight or buffered

Behaviour:
- Reset: all outputs 0; round-robin pointer = 0; FIFO empty; in-flight count = 0; FSM in RUN.
- Credit: credit_ok = (fifo_count + inflight) < OUT_DEPTH. A pop in the current cycle does not return credit until the next cycle.
- Arbitration: when FSM = RUN and credit_ok, grant the first asserted req_valid_i[k], searching k = ptr, ptr+1, … mod NUM_REQ.
  - req_ready_o is one-hot with the grant, or all zeros.
  - req_ready_o may depend combinationally on req_valid_i; req_valid_i must not depend on req_ready_o.
- Pointer: after a grant to k, ptr = (k+1) mod NUM_REQ, wrapping at NUM_REQ-1 → 0. Without a grant, ptr is unchanged.
- Issue: an accept at the edge ending cycle T registers data and ID. enc_valid_o and enc_data_o are high/valid during cycle T+1.
- ID and valid travel through a shadow pipeline of ENC_LATENCY stages.
- enc_coded_i is sampled in cycle T+1+ENC_LATENCY and pushed into the FIFO at the end of that cycle.
- Latency: out_valid_o rises at T+2+ENC_LATENCY when the FIFO was empty. There is no bypass path.
- Throughput: one word per cycle when out_ready_i is held high.
- Output: FIFO head is shown on out_data_o/out_id_o; it pops on out_valid_o && out_ready_i. Push and pop in the same cycle both occur and leave count unchanged.
- Full FIFO: overflow is impossible by construction. Bench asserts fifo_count <= OUT_DEPTH.
- inflight: increments on accept and decrements on FIFO push; both in one cycle leaves it unchanged.
- FSM:
  - RUN: grants allowed. flush_i → DRAIN; a grant in the same cycle as flush_i is still honoured.
  - DRAIN: no grants. When inflight == 0 and FIFO is empty → DONE.
  - DONE: flush_done_o = 1 for one cycle → RUN.
  - flush_i while in DRAIN or DONE is ignored.
- busy_o = (inflight != 0) || (fifo_count != 0).
- Reset mid-operation: in-flight and buffered words are discarded. Encoder results arriving after reset are ignored because the shadow valids are cleared.

Optional Feature:
- Macro HAMMING_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt_o (NUM_REQ*16): per-requester saturating grant counters, saturating at 16'hFFFF.
  - Adds output stall_cnt_o (16): saturating count of cycles with any req_valid_i high and no grant.
  - All counters clear on rst_i.
- Undefined: these ports and counters do not exist, and core behaviour is identical.

Test Plan:
- Single requester, ENC_LATENCY=1: req 2 sends 32'hDEADBEEF accepted in cycle 5 → enc_valid_o in cycle 6 with enc_data_o=32'hDEADBEEF; out_valid_o in cycle 8 with out_id_o=2 and out_data_o = model code.
- All 4 requesters valid continuously, out_ready_i=1 → grants in order 0,1,2,3,0,…; one accept per cycle; output ID order matches grant order.
- out_ready_i=0 with all requesters valid → exactly OUT_DEPTH=4 accepts, then req_ready_o=0. Raising out_ready_i resumes grants one cycle after the first pop.
- Requesters 1 and 3 valid, ptr=2 → grant to 3, then 1, then 3; ptr wraps from 3 to 0.
- flush_i with 3 words buffered and 1 in flight, out_ready_i=1 → no grants during DRAIN; flush_done_o pulses one cycle after the last pop; busy_o=0 at that cycle; grants resume the next cycle.
- rst_i asserted with 2 in flight and 2 buffered → next cycle out_valid_o=0, busy_o=0, ptr=0; late enc_coded_i is not pushed.
